// File: rtl/axi_lite_regfile_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_lite_regfile_slave_if                                    |
// | Description : AXI4-Lite bus bundle for the register-file responder.        |
// |               Signal names carry the direction suffix as seen by the       |
// |               responder (slave modport): *_i are driven by the master,     |
// |               *_o by the responder.                                        |
// | Ports       : AW channel  awaddr_i, awvalid_i, awready_o                   |
// |               W channel   wdata_i, wstrb_i, wvalid_i, wready_o             |
// |               B channel   bresp_o, bvalid_o, bready_i                      |
// |               AR channel  araddr_i, arvalid_i, arready_o                   |
// |               R channel   rdata_o, rresp_o, rvalid_o, rready_i             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface axi_lite_regfile_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // Write address channel
  logic [ADDR_WIDTH-1:0]   awaddr_i;
  logic                    awvalid_i;
  logic                    awready_o;
  // Write data channel
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic [DATA_WIDTH/8-1:0] wstrb_i;
  logic                    wvalid_i;
  logic                    wready_o;
  // Write response channel
  logic [1:0]              bresp_o;
  logic                    bvalid_o;
  logic                    bready_i;
  // Read address channel
  logic [ADDR_WIDTH-1:0]   araddr_i;
  logic                    arvalid_i;
  logic                    arready_o;
  // Read data channel
  logic [DATA_WIDTH-1:0]   rdata_o;
  logic [1:0]              rresp_o;
  logic                    rvalid_o;
  logic                    rready_i;

  modport master (
    output awaddr_i, awvalid_i, input awready_o,
    output wdata_i, wstrb_i, wvalid_i, input wready_o,
    input  bresp_o, bvalid_o, output bready_i,
    output araddr_i, arvalid_i, input arready_o,
    input  rdata_o, rresp_o, rvalid_o, output rready_i
  );

  modport slave (
    input  awaddr_i, awvalid_i, output awready_o,
    input  wdata_i, wstrb_i, wvalid_i, output wready_o,
    output bresp_o, bvalid_o, input bready_i,
    input  araddr_i, arvalid_i, output arready_o,
    output rdata_o, rresp_o, rvalid_o, input rready_i
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_regfile_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_lite_regfile_slave                                       |
// | Description : AXI4-Lite responder hosting NUM_REGS software-visible        |
// |               32-bit registers. Register 0 is a read-only ID word.         |
// |               Write and read channels are independent, each with at most   |
// |               one transaction in flight.                                   |
// | Ports       : clk_i   core clock                                           |
// |               rst_ni  asynchronous active-low reset                        |
// |               bus     axi_lite_regfile_slave_if.slave (AW/W/B/AR/R)        |
// | Config      : AXI_REGS_SLVERR_EN - when defined, out-of-range accesses     |
// |               return SLVERR, writes are dropped and reads return 0. When   |
// |               undefined, out-of-range offsets alias onto the bank and all  |
// |               responses are OKAY.                                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module axi_lite_regfile_slave #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,          // only 32 supported
  parameter int unsigned NUM_REGS    = 16,          // power of two, 2..256
  parameter int unsigned WINDOW_BITS = 12,          // decoded byte-offset bits
  parameter logic [31:0] ID_VALUE    = 32'hCE90_0001
) (
  input wire clk_i,
  input wire rst_ni,
  axi_lite_regfile_slave_if.slave bus
);

  localparam int unsigned c_idx_w     = $clog2(NUM_REGS);
  localparam int unsigned c_strb_w    = DATA_WIDTH / 8;
  localparam logic [1:0]  c_resp_okay = 2'b00;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                   ready_en_q, ready_en_d;

  logic                   aw_full_q,  aw_full_d;
  logic                   w_full_q,   w_full_d;
  logic                   bvalid_q,   bvalid_d;
  logic [WINDOW_BITS-1:0] awoff_q,    awoff_d;
  logic [DATA_WIDTH-1:0]  wdata_q,    wdata_d;
  logic [c_strb_w-1:0]    wstrb_q,    wstrb_d;
  logic [1:0]             bresp_q,    bresp_d;

  logic                   rvalid_q,   rvalid_d;
  logic [DATA_WIDTH-1:0]  rdata_q,    rdata_d;
  logic [1:0]             rresp_q,    rresp_d;

  // Register 0 has no storage; it is the constant ID_VALUE.
  logic [DATA_WIDTH-1:0]  regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0]  regs_d [1:NUM_REGS-1];

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic                   w_awready, w_wready, w_arready;
  logic                   w_aw_hs, w_w_hs, w_ar_hs;
  logic                   w_do_write;
  logic [WINDOW_BITS-1:0] w_wr_off, w_rd_off;
  logic [c_idx_w-1:0]     w_wr_idx, w_rd_idx;
  logic [DATA_WIDTH-1:0]  w_wr_data;
  logic [c_strb_w-1:0]    w_wr_strb;
  logic                   w_wr_ok, w_rd_ok;
  logic [1:0]             w_wr_resp, w_rd_resp;
  logic [DATA_WIDTH-1:0]  w_rd_word;
  logic                   w_unused_bits;

  // Readies depend only on flops; no input reaches an output combinationally.
  assign w_awready = !aw_full_q && !bvalid_q && ready_en_q;
  assign w_wready  = !w_full_q  && !bvalid_q && ready_en_q;
  assign w_arready = !rvalid_q  && ready_en_q;

  assign w_aw_hs = bus.awvalid_i && w_awready;
  assign w_w_hs  = bus.wvalid_i  && w_wready;
  assign w_ar_hs = bus.arvalid_i && w_arready;

  // Take address/data from the holding flops if already captured, otherwise
  // straight from the bus on the handshake cycle, so a write commits on the
  // same edge the second half arrives.
  assign w_wr_off  = aw_full_q ? awoff_q : bus.awaddr_i[WINDOW_BITS-1:0];
  assign w_wr_data = w_full_q  ? wdata_q : bus.wdata_i;
  assign w_wr_strb = w_full_q  ? wstrb_q : bus.wstrb_i;
  assign w_rd_off  = bus.araddr_i[WINDOW_BITS-1:0];

  assign w_wr_idx = w_wr_off[2 +: c_idx_w];
  assign w_rd_idx = w_rd_off[2 +: c_idx_w];

  assign w_do_write = (aw_full_q || w_aw_hs) && (w_full_q || w_w_hs);

`ifdef AXI_REGS_SLVERR_EN
  localparam logic [1:0] c_resp_slverr = 2'b10;

  // In range when no offset bit above the index field is set.
  assign w_wr_ok   = (w_wr_off[WINDOW_BITS-1:c_idx_w+2] == '0);
  assign w_rd_ok   = (w_rd_off[WINDOW_BITS-1:c_idx_w+2] == '0);
  assign w_wr_resp = w_wr_ok ? c_resp_okay : c_resp_slverr;
  assign w_rd_resp = w_rd_ok ? c_resp_okay : c_resp_slverr;
`else
  // Upper offset bits are ignored, so every offset aliases onto the bank.
  assign w_wr_ok   = 1'b1;
  assign w_rd_ok   = 1'b1;
  assign w_wr_resp = c_resp_okay;
  assign w_rd_resp = c_resp_okay;
`endif

  // Address bits above the window and the byte-within-word bits carry no
  // meaning here.
  assign w_unused_bits = ^{bus.awaddr_i, bus.araddr_i, awoff_q, w_wr_off, w_rd_off};

  // Read mux works on the current flop contents, so a write committing on the
  // same edge is not visible to this read.
  always_comb begin
    w_rd_word = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (w_rd_idx == c_idx_w'(i)) begin
        w_rd_word = regs_q[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    ready_en_d = 1'b1;

    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    bvalid_d  = bvalid_q;
    awoff_d   = awoff_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;

    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    // Write channel. Address and data can arrive in either order; the write
    // commits as soon as both are present. Neither handshake is accepted
    // while a response is pending, so bvalid_q is low whenever w_do_write is.
    if (w_do_write) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = w_wr_resp;
    end else begin
      if (w_aw_hs) begin
        aw_full_d = 1'b1;
        awoff_d   = bus.awaddr_i[WINDOW_BITS-1:0];
      end
      if (w_w_hs) begin
        w_full_d = 1'b1;
        wdata_d  = bus.wdata_i;
        wstrb_d  = bus.wstrb_i;
      end
      if (bvalid_q && bus.bready_i) begin
        bvalid_d = 1'b0;
      end
    end

    // Read channel
    if (w_ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = w_rd_ok ? w_rd_word : '0;
      rresp_d  = w_rd_resp;
    end else if (rvalid_q && bus.rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  // Register bank update with byte-lane strobes.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (w_do_write && w_wr_ok && (w_wr_idx == c_idx_w'(i))) begin
        for (int b = 0; b < c_strb_w; b++) begin
          if (w_wr_strb[b]) begin
            regs_d[i][8*b +: 8] = w_wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Flops
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_en_q <= 1'b0;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      awoff_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
    end else begin
      ready_en_q <= ready_en_d;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      bvalid_q   <= bvalid_d;
      awoff_q    <= awoff_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.awready_o = w_awready;
  assign bus.wready_o  = w_wready;
  assign bus.bvalid_o  = bvalid_q;
  assign bus.bresp_o   = bresp_q;
  assign bus.arready_o = w_arready;
  assign bus.rvalid_o  = rvalid_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.rresp_o   = rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axi_lite_regfile_slave                                    |
// | Description : Self-checking bench for axi_lite_regfile_slave. A            |
// |               transaction-level model predicts every output each cycle;    |
// |               directed sequences add literal expectations.                 |
// | Config      : follows AXI_REGS_SLVERR_EN the same way as the design.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_axi_lite_regfile_slave;

  localparam int          NREG = 16;
  localparam logic [31:0] ID   = 32'hCE90_0001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  axi_lite_regfile_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_regfile_slave dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=no-handshake expected=handshake at %0t", name, $time);
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: pending-request bits, a plain register array and
  // address arithmetic (word = (addr mod 4096) / 4).
  // --------------------------------------------------------------------------
  bit        m_ren, m_awp, m_wp, m_bv, m_rv;
  bit [31:0] m_awaddr, m_wdata, m_rdata;
  bit [3:0]  m_wstrb;
  bit [1:0]  m_bresp, m_rresp;
  bit [31:0] m_regs [NREG];

  task automatic m_read(input bit [31:0] addr, output bit [31:0] data, output bit [1:0] resp);
    int w;
    w = int'(addr % 32'd4096) / 4;
`ifdef AXI_REGS_SLVERR_EN
    if (w >= NREG) begin
      data = 32'h0;
      resp = 2'b10;
      return;
    end
`else
    w = w % NREG;
`endif
    data = (w == 0) ? ID : m_regs[w];
    resp = 2'b00;
  endtask

  task automatic m_write(input bit [31:0] addr, input bit [31:0] data, input bit [3:0] strb,
                         output bit [1:0] resp);
    int w;
    w = int'(addr % 32'd4096) / 4;
`ifdef AXI_REGS_SLVERR_EN
    if (w >= NREG) begin
      resp = 2'b10;
      return;
    end
`else
    w = w % NREG;
`endif
    resp = 2'b00;
    if (w != 0) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) m_regs[w][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model_step
    bit aw_rdy, w_rdy, ar_rdy;
    if (!rst_n) begin
      m_ren = 0; m_awp = 0; m_wp = 0; m_bv = 0; m_rv = 0;
      m_bresp = 0; m_rresp = 0; m_rdata = 0;
      for (int i = 0; i < NREG; i++) m_regs[i] = 0;
    end else begin
      aw_rdy = m_ren && !m_awp && !m_bv;
      w_rdy  = m_ren && !m_wp  && !m_bv;
      ar_rdy = m_ren && !m_rv;
      // Read first so a same-edge write is not visible to it.
      if (bus.arvalid_i && ar_rdy) begin
        m_read(bus.araddr_i, m_rdata, m_rresp);
        m_rv = 1;
      end else if (m_rv && bus.rready_i) begin
        m_rv = 0;
      end
      if (m_bv && bus.bready_i) m_bv = 0;
      if (bus.awvalid_i && aw_rdy) begin
        m_awp = 1;
        m_awaddr = bus.awaddr_i;
      end
      if (bus.wvalid_i && w_rdy) begin
        m_wp = 1;
        m_wdata = bus.wdata_i;
        m_wstrb = bus.wstrb_i;
      end
      if (m_awp && m_wp) begin
        m_write(m_awaddr, m_wdata, m_wstrb, m_bresp);
        m_awp = 0;
        m_wp  = 0;
        m_bv  = 1;
      end
      m_ren = 1;
    end
  end

  // Compare process: every output, every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("awready", {31'b0, bus.awready_o}, {31'b0, m_ren && !m_awp && !m_bv});
    chk("wready",  {31'b0, bus.wready_o},  {31'b0, m_ren && !m_wp && !m_bv});
    chk("arready", {31'b0, bus.arready_o}, {31'b0, m_ren && !m_rv});
    chk("bvalid",  {31'b0, bus.bvalid_o},  {31'b0, m_bv});
    chk("rvalid",  {31'b0, bus.rvalid_o},  {31'b0, m_rv});
    if (m_bv) chk("bresp", {30'b0, bus.bresp_o}, {30'b0, m_bresp});
    if (m_rv) begin
      chk("rdata", bus.rdata_o, m_rdata);
      chk("rresp", {30'b0, bus.rresp_o}, {30'b0, m_rresp});
    end
  end

  // --------------------------------------------------------------------------
  // Drivers (called at a falling edge, return at a falling edge)
  // --------------------------------------------------------------------------
  task automatic wr_issue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int  n;
    bit  aw_f, w_f;
    bus.awaddr_i  = addr;
    bus.awvalid_i = 1'b1;
    bus.wdata_i   = data;
    bus.wstrb_i   = strb;
    bus.wvalid_i  = 1'b1;
    n = 0;
    while ((bus.awvalid_i || bus.wvalid_i) && n < 20) begin
      aw_f = bus.awvalid_i && bus.awready_o;
      w_f  = bus.wvalid_i  && bus.wready_o;
      @(negedge clk);
      n++;
      if (aw_f) bus.awvalid_i = 1'b0;
      if (w_f)  bus.wvalid_i  = 1'b0;
    end
    if (bus.awvalid_i || bus.wvalid_i) begin
      timeout("wr_issue");
      bus.awvalid_i = 1'b0;
      bus.wvalid_i  = 1'b0;
    end
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n = 0;
    bus.bready_i = 1'b1;
    while (!bus.bvalid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.bvalid_o) timeout("wait_b");
    resp = bus.bresp_o;
    @(negedge clk);
    bus.bready_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    output logic [1:0] resp);
    wr_issue(addr, data, strb);
    wait_b(resp);
  endtask

  task automatic rd_issue(input logic [31:0] addr);
    int n = 0;
    bus.araddr_i  = addr;
    bus.arvalid_i = 1'b1;
    while (!bus.arready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.arready_o) timeout("rd_issue");
    @(negedge clk);
    bus.arvalid_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    rd_issue(addr);
    bus.rready_i = 1'b1;
    while (!bus.rvalid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rvalid_o) timeout("rd_wait");
    data = bus.rdata_o;
    resp = bus.rresp_o;
    @(negedge clk);
    bus.rready_i = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          n;

    bus.awaddr_i = '0; bus.awvalid_i = 1'b0;
    bus.wdata_i  = '0; bus.wstrb_i   = '0; bus.wvalid_i = 1'b0;
    bus.bready_i = 1'b0;
    bus.araddr_i = '0; bus.arvalid_i = 1'b0;
    bus.rready_i = 1'b0;

    // Reset values, and readies held low until the first edge after release.
    repeat (2) @(negedge clk);
    chk("rst_bvalid", {31'b0, bus.bvalid_o}, 32'd0);
    chk("rst_rdata",  bus.rdata_o, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_awready", {31'b0, bus.awready_o}, 32'd0);
    @(negedge clk);
    chk("ena_arready", {31'b0, bus.arready_o}, 32'd1);

    // ID register, and writes to it are ignored but acknowledged.
    rd(32'h0, d, r);
    chk("id_rdata", d, ID);
    chk("id_rresp", {30'b0, r}, 32'd0);
    wr(32'h0, 32'hFFFF_FFFF, 4'hF, r);
    chk("id_wr_bresp", {30'b0, r}, 32'd0);
    rd(32'h0, d, r);
    chk("id_after_wr", d, ID);

    // W before AW, response held off by bready low for three cycles.
    bus.wdata_i  = 32'hA5A5_1234;
    bus.wstrb_i  = 4'hF;
    bus.wvalid_i = 1'b1;
    n = 0;
    while (!bus.wready_o && n < 20) begin @(negedge clk); n++; end
    if (!bus.wready_o) timeout("w_only");
    @(negedge clk);
    bus.wvalid_i = 1'b0;
    @(negedge clk);
    bus.awaddr_i  = 32'h8;
    bus.awvalid_i = 1'b1;
    n = 0;
    while (!bus.awready_o && n < 20) begin @(negedge clk); n++; end
    if (!bus.awready_o) timeout("aw_late");
    @(negedge clk);
    bus.awvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("b_hold_valid", {31'b0, bus.bvalid_o}, 32'd1);
      chk("b_hold_resp",  {30'b0, bus.bresp_o},  32'd0);
      @(negedge clk);
    end
    wait_b(r);
    chk("w_first_bresp", {30'b0, r}, 32'd0);
    rd(32'h8, d, r);
    chk("rd_0x8", d, 32'hA5A5_1234);
    // Lanes 0 and 2 take 0x00; lanes 1 and 3 keep 0x12 and 0xA5.
    wr(32'h8, 32'h0000_FF00, 4'b0101, r);
    chk("w_strb_bresp", {30'b0, r}, 32'd0);
    rd(32'h8, d, r);
    chk("rd_0x8_strb", d, 32'hA500_1200);

    // Single-lane strobe and the top register.
    wr(32'hC, 32'h1122_3344, 4'b1000, r);
    rd(32'hC, d, r);
    chk("rd_lane3", d, 32'h1100_0000);
    wr(32'h3C, 32'hDEAD_BEEF, 4'hF, r);
    rd(32'h3C, d, r);
    chk("rd_top", d, 32'hDEAD_BEEF);

    // Same-edge read and write of reg1: the read sees the old value.
    wr(32'h4, 32'h7, 4'hF, r);
    bus.araddr_i  = 32'h4; bus.arvalid_i = 1'b1;
    bus.awaddr_i  = 32'h4; bus.awvalid_i = 1'b1;
    bus.wdata_i   = 32'h1; bus.wstrb_i   = 4'hF; bus.wvalid_i = 1'b1;
    chk("same_readies", {29'b0, bus.arready_o, bus.awready_o, bus.wready_o}, 32'd7);
    @(negedge clk);
    bus.arvalid_i = 1'b0; bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
    chk("same_rvalid", {31'b0, bus.rvalid_o}, 32'd1);
    chk("same_rdata",  bus.rdata_o, 32'h7);
    chk("same_bvalid", {31'b0, bus.bvalid_o}, 32'd1);
    bus.rready_i = 1'b1; bus.bready_i = 1'b1;
    @(negedge clk);
    bus.rready_i = 1'b0; bus.bready_i = 1'b0;
    rd(32'h4, d, r);
    chk("after_same", d, 32'h1);

    // Upper address bits beyond the window are ignored.
    rd(32'h1000_0004, d, r);
    chk("hi_addr_ignored", d, 32'h1);

    // Out-of-range offsets.
`ifdef AXI_REGS_SLVERR_EN
    wr(32'h40, 32'h55, 4'hF, r);
    chk("oor_bresp", {30'b0, r}, 32'd2);
    rd(32'h40, d, r);
    chk("oor_rresp", {30'b0, r}, 32'd2);
    chk("oor_rdata", d, 32'h0);
    rd(32'h4, d, r);
    chk("oor_reg1_kept", d, 32'h1);
    rd(32'h0, d, r);
    chk("oor_reg0_kept", d, ID);
`else
    wr(32'h40, 32'h55, 4'hF, r);
    chk("alias_bresp", {30'b0, r}, 32'd0);
    rd(32'h40, d, r);
    chk("alias_reg0", d, ID);
    chk("alias_rresp", {30'b0, r}, 32'd0);
    wr(32'h44, 32'h1234_5678, 4'hF, r);
    rd(32'h4, d, r);
    chk("alias_reg1", d, 32'h1234_5678);
`endif

    // Reset with both a write response and a read response pending.
    wr_issue(32'h8, 32'h99, 4'hF);
    rd_issue(32'h4);
    chk("pre_rst_bvalid", {31'b0, bus.bvalid_o}, 32'd1);
    chk("pre_rst_rvalid", {31'b0, bus.rvalid_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_bvalid",  {31'b0, bus.bvalid_o}, 32'd0);
    chk("async_rvalid",  {31'b0, bus.rvalid_o}, 32'd0);
    chk("async_awready", {31'b0, bus.awready_o}, 32'd0);
    chk("async_rdata",   bus.rdata_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel2_arready", {31'b0, bus.arready_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel2_arready_up", {31'b0, bus.arready_o}, 32'd1);
    @(negedge clk);
    rd(32'h4, d, r);
    chk("reg1_cleared", d, 32'h0);
    rd(32'h8, d, r);
    chk("reg2_cleared", d, 32'h0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
